// File: rtl/sha256core_loader.sv
// Producer-side front end for one sha256core: picks a free core input slot
// round-robin, streams a 16-word block into it, then marks the slot valid.
module sha256core_loader #(
  parameter int         BLK_OP_W = 2,
  parameter logic [1:0] RR_INIT  = 2'd0
) (
  input  logic                CLK,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [31:0]         in_data,
  input  logic [BLK_OP_W-1:0] in_blk_op,
  output logic                in_ready,
  input  logic [3:0]          core_ready,
  output logic                wr_en,
  output logic [31:0]         dout,
  output logic [3:0]          wr_addr,
  output logic [BLK_OP_W-1:0] blk_op,
  output logic                out_ctx,
  output logic                out_seq,
  output logic                set_input_ready,
  output logic                busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOAD = 1'b1;

  logic [0:0]          state_q,   state_d;
  logic [1:0]          rrPtr_q,   rrPtr_d;
  logic [3:0]          claimed_q, claimed_d;
  logic [3:0]          wcnt_q,    wcnt_d;
  logic [1:0]          slot_q,    slot_d;
  logic [BLK_OP_W-1:0] op_q,      op_d;
  logic                wrEn_q,    wrEn_d;
  logic [31:0]         dout_q,    dout_d;
  logic [3:0]          wrAddr_q,  wrAddr_d;
  logic                sir_q,     sir_d;
  logic [BLK_OP_W-1:0] blkOp_q,   blkOp_d;

  logic [3:0] freeSlots;
  logic       pickValid;
  logic [1:0] pickSlot;
  logic [1:0] cand;
  logic       xfer;

  // A slot the loader has started writing stays claimed until the core is
  // seen dropping its ready bit, so the stale ready cannot be re-chosen.
  assign freeSlots = core_ready & ~claimed_q;
  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q == LOAD);
  assign xfer      = in_valid & in_ready;

  // Descending scan so the candidate closest to rrPtr_q wins.
  always_comb begin
    pickValid = 1'b0;
    pickSlot  = rrPtr_q;
    cand      = rrPtr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = rrPtr_q + 2'(k);
      if (freeSlots[cand]) begin
        pickValid = 1'b1;
        pickSlot  = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rrPtr_d   = rrPtr_q;
    claimed_d = claimed_q & core_ready;
    wcnt_d    = wcnt_q;
    slot_d    = slot_q;
    op_d      = op_q;
    wrEn_d    = 1'b0;
    dout_d    = dout_q;
    wrAddr_d  = wrAddr_q;
    sir_d     = 1'b0;
    blkOp_d   = blkOp_q;
    case (state_q)
      IDLE: begin
        if (pickValid) begin
          slot_d  = pickSlot;
          rrPtr_d = pickSlot + 2'd1;
          wcnt_d  = 4'd0;
          state_d = LOAD;
        end
      end
      default: begin
        if (xfer) begin
          wrEn_d   = 1'b1;
          dout_d   = in_data;
          wrAddr_d = wcnt_q;
          wcnt_d   = wcnt_q + 4'd1;
          if (wcnt_q == 4'd0) begin
            op_d              = in_blk_op;
            claimed_d[slot_q] = 1'b1;
          end
          if (wcnt_q == 4'd15) begin
            sir_d   = 1'b1;
            blkOp_d = op_q;
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rrPtr_q   <= RR_INIT;
      claimed_q <= 4'b0000;
      wcnt_q    <= 4'd0;
      slot_q    <= 2'd0;
      op_q      <= '0;
      wrEn_q    <= 1'b0;
      dout_q    <= 32'd0;
      wrAddr_q  <= 4'd0;
      sir_q     <= 1'b0;
      blkOp_q   <= '0;
    end else begin
      state_q   <= state_d;
      rrPtr_q   <= rrPtr_d;
      claimed_q <= claimed_d;
      wcnt_q    <= wcnt_d;
      slot_q    <= slot_d;
      op_q      <= op_d;
      wrEn_q    <= wrEn_d;
      dout_q    <= dout_d;
      wrAddr_q  <= wrAddr_d;
      sir_q     <= sir_d;
      blkOp_q   <= blkOp_d;
    end
  end

  assign wr_en           = wrEn_q;
  assign dout            = dout_q;
  assign wr_addr         = wrAddr_q;
  assign set_input_ready = sir_q;
  assign blk_op          = blkOp_q;
  assign out_ctx         = slot_q[1];
  assign out_seq         = slot_q[0];

endmodule
